// File: rtl/xyolo_conv_seq_if.sv
// Bus between a convolution sequencer and its controller / xyolo datapath.
interface xyolo_conv_seq_if #(
  parameter int unsigned MEM_ADDR_W    = 10,
  parameter int unsigned VWRITE_ADDR_W = 10,
  parameter int unsigned DIM_W         = 8
);

  logic                     run;
  logic                     done;
  logic [MEM_ADDR_W-1:0]    base_addr;
  logic [DIM_W-1:0]         in_w;
  logic [DIM_W-1:0]         stride;
  logic [DIM_W-1:0]         ker_w;
  logic [DIM_W-1:0]         ker_h;
  logic [DIM_W-1:0]         out_w;
  logic [DIM_W-1:0]         out_h;
  logic [VWRITE_ADDR_W-1:0] vwrite_base;
  logic                     maxpool_en;
  logic                     vread_enB;
  logic [MEM_ADDR_W-1:0]    vread_addrB;
  logic                     vwrite_enB;
  logic [VWRITE_ADDR_W-1:0] vwrite_addrB;
  logic                     ld_acc;
  logic                     ld_mp;
  logic                     ld_res;

  modport master (
    output run, base_addr, in_w, stride, ker_w, ker_h, out_w, out_h,
           vwrite_base, maxpool_en,
    input  done, vread_enB, vread_addrB, vwrite_enB, vwrite_addrB,
           ld_acc, ld_mp, ld_res
  );

  modport slave (
    input  run, base_addr, in_w, stride, ker_w, ker_h, out_w, out_h,
           vwrite_base, maxpool_en,
    output done, vread_enB, vread_addrB, vwrite_enB, vwrite_addrB,
           ld_acc, ld_mp, ld_res
  );

endinterface

// File: rtl/xyolo_conv_seq.sv
// Convolution tap sequencer: walks kx/ky/ox/oy, issues vread taps and
// the delayed xyolo strobes and vwrite enables for every output.
module xyolo_conv_seq #(
  parameter int unsigned MEM_ADDR_W    = 10,
  parameter int unsigned VWRITE_ADDR_W = 10,
  parameter int unsigned DIM_W         = 8,
  parameter int unsigned WR_LAT        = 3
) (
  input  logic            clk,
  input  logic            rst,
  xyolo_conv_seq_if.slave bus
);

  localparam int unsigned DRAIN_LAST = WR_LAT + 1;
  localparam int unsigned DRAIN_W    = $clog2(WR_LAT + 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DIM_W-1:0]         r_in_w;
  logic [DIM_W-1:0]         r_stride;
  logic [DIM_W-1:0]         r_ker_w;
  logic [DIM_W-1:0]         r_ker_h;
  logic [DIM_W-1:0]         r_out_w;
  logic [DIM_W-1:0]         r_out_h;
  logic                     r_maxpool;

  logic [DIM_W-1:0]         r_kx;
  logic [DIM_W-1:0]         r_ky;
  logic [DIM_W-1:0]         r_ox;
  logic [DIM_W-1:0]         r_oy;
  logic [MEM_ADDR_W-1:0]    r_row_base;
  logic [MEM_ADDR_W-1:0]    r_out_base;
  logic [MEM_ADDR_W-1:0]    r_ker_row;
  logic [MEM_ADDR_W-1:0]    r_vread_addr;
  logic                     r_vread_en;
  logic                     r_done;
  logic [DRAIN_W-1:0]       r_drain;

  logic                     r_acc_d1;
  logic                     r_res_d1;
  logic                     r_ld_acc;
  logic                     r_ld_res;
  logic                     r_ld_mp;
  logic [WR_LAT-1:0]        r_wr_sr;
  logic [VWRITE_ADDR_W-1:0] r_wr_ptr;
  logic [VWRITE_ADDR_W-1:0] r_vwrite_addr;

  logic                     w_cfg_zero;
  logic                     w_accept;
  logic                     w_start;
  logic                     w_advance;
  logic                     w_tap_en;
  logic                     w_done_nxt;
  logic                     w_kx_last;
  logic                     w_ky_last;
  logic                     w_ox_last;
  logic                     w_oy_last;
  logic                     w_tap_last;
  logic                     w_tap_first;
  logic                     w_out_last;
  logic                     w_drain_end;
  logic [MEM_ADDR_W-1:0]    w_in_w_ext;
  logic [MEM_ADDR_W-1:0]    w_stride_ext;
  logic [MEM_ADDR_W-1:0]    w_row_step;
  logic [MEM_ADDR_W-1:0]    w_next_ker;
  logic [MEM_ADDR_W-1:0]    w_next_out;
  logic [MEM_ADDR_W-1:0]    w_next_row;
  logic [WR_LAT:0]          w_wr_shift;
  logic                     w_wr_fire;

  assign w_cfg_zero  = (bus.ker_w == '0) || (bus.ker_h == '0) ||
                       (bus.out_w == '0) || (bus.out_h == '0);
  assign w_kx_last   = (r_kx == r_ker_w - DIM_W'(1));
  assign w_ky_last   = (r_ky == r_ker_h - DIM_W'(1));
  assign w_ox_last   = (r_ox == r_out_w - DIM_W'(1));
  assign w_oy_last   = (r_oy == r_out_h - DIM_W'(1));
  assign w_out_last  = w_kx_last && w_ky_last;
  assign w_tap_last  = w_out_last && w_ox_last && w_oy_last;
  assign w_tap_first = (r_kx == '0) && (r_ky == '0);
  assign w_drain_end = (r_drain == DRAIN_W'(DRAIN_LAST));

  assign w_in_w_ext   = MEM_ADDR_W'(r_in_w);
  assign w_stride_ext = MEM_ADDR_W'(r_stride);
  assign w_next_ker   = r_ker_row + w_in_w_ext;
  assign w_next_out   = r_out_base + w_stride_ext;
  assign w_next_row   = r_row_base + w_row_step;

  // ld_res enters a shift line; the stage before the output marks the write
  assign w_wr_shift = {r_wr_sr, r_ld_res};
  assign w_wr_fire  = w_wr_shift[WR_LAT-1];

  // stride*in_w as a shift-and-add of the latched config (used only at row wrap)
  always_comb begin
    w_row_step = '0;
    for (int i = 0; i < int'(DIM_W); i++) begin
      if (r_stride[i]) w_row_step = w_row_step + (w_in_w_ext << i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.run) w_state_nxt = w_cfg_zero ? S_FLUSH : S_RUN;
      S_RUN:   if (w_tap_last) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    w_accept  = 1'b0;
    w_start   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.run;
        w_start  = bus.run && !w_cfg_zero;
      end
      S_RUN:   w_advance = !w_tap_last;
      default: ;
    endcase
    w_tap_en   = w_start || w_advance;
    w_done_nxt = (w_state_nxt == S_IDLE);
  end

  // Configuration latch on the accepted run cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_w    <= '0;
      r_stride  <= '0;
      r_ker_w   <= '0;
      r_ker_h   <= '0;
      r_out_w   <= '0;
      r_out_h   <= '0;
      r_maxpool <= 1'b0;
    end else if (w_accept) begin
      r_in_w    <= bus.in_w;
      r_stride  <= bus.stride;
      r_ker_w   <= bus.ker_w;
      r_ker_h   <= bus.ker_h;
      r_out_w   <= bus.out_w;
      r_out_h   <= bus.out_h;
      r_maxpool <= bus.maxpool_en;
    end
  end

  // Loop counters and running-sum tap address
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kx         <= '0;
      r_ky         <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_row_base   <= '0;
      r_out_base   <= '0;
      r_ker_row    <= '0;
      r_vread_addr <= '0;
    end else if (w_start) begin
      r_kx         <= '0;
      r_ky         <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_row_base   <= bus.base_addr;
      r_out_base   <= bus.base_addr;
      r_ker_row    <= bus.base_addr;
      r_vread_addr <= bus.base_addr;
    end else if (w_advance) begin
      if (!w_kx_last) begin
        r_kx         <= r_kx + DIM_W'(1);
        r_vread_addr <= r_vread_addr + MEM_ADDR_W'(1);
      end else if (!w_ky_last) begin
        r_kx         <= '0;
        r_ky         <= r_ky + DIM_W'(1);
        r_ker_row    <= w_next_ker;
        r_vread_addr <= w_next_ker;
      end else if (!w_ox_last) begin
        r_kx         <= '0;
        r_ky         <= '0;
        r_ox         <= r_ox + DIM_W'(1);
        r_out_base   <= w_next_out;
        r_ker_row    <= w_next_out;
        r_vread_addr <= w_next_out;
      end else begin
        r_kx         <= '0;
        r_ky         <= '0;
        r_ox         <= '0;
        r_oy         <= r_oy + DIM_W'(1);
        r_row_base   <= w_next_row;
        r_out_base   <= w_next_row;
        r_ker_row    <= w_next_row;
        r_vread_addr <= w_next_row;
      end
    end
  end

  // Read enable, done flag and flush drain counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vread_en <= 1'b0;
      r_done     <= 1'b1;
      r_drain    <= '0;
    end else begin
      r_vread_en <= w_tap_en;
      r_done     <= w_done_nxt;
      if (w_accept && w_cfg_zero)  r_drain <= DRAIN_W'(DRAIN_LAST);
      else if (r_state == S_FLUSH) r_drain <= r_drain + DRAIN_W'(1);
      else                         r_drain <= '0;
    end
  end

  // Strobe delay lines; each tap's flags ride with it so outputs can overlap
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc_d1      <= 1'b0;
      r_res_d1      <= 1'b0;
      r_ld_acc      <= 1'b0;
      r_ld_res      <= 1'b0;
      r_ld_mp       <= 1'b0;
      r_wr_sr       <= '0;
      r_wr_ptr      <= '0;
      r_vwrite_addr <= '0;
    end else begin
      r_acc_d1 <= r_vread_en && w_tap_first;
      r_res_d1 <= r_vread_en && w_out_last;
      r_ld_acc <= r_acc_d1;
      r_ld_res <= r_res_d1;
      r_ld_mp  <= r_res_d1 && r_maxpool;
      r_wr_sr  <= w_wr_shift[WR_LAT-1:0];
      if (w_accept) begin
        r_wr_ptr <= bus.vwrite_base;
      end else if (w_wr_fire) begin
        r_wr_ptr      <= r_wr_ptr + VWRITE_ADDR_W'(1);
        r_vwrite_addr <= r_wr_ptr;
      end
    end
  end

  assign bus.done         = r_done;
  assign bus.vread_enB    = r_vread_en;
  assign bus.vread_addrB  = r_vread_addr;
  assign bus.vwrite_enB   = r_wr_sr[WR_LAT-1];
  assign bus.vwrite_addrB = r_vwrite_addr;
  assign bus.ld_acc       = r_ld_acc;
  assign bus.ld_mp        = r_ld_mp;
  assign bus.ld_res       = r_ld_res;

endmodule

// File: tb/tb_xyolo_conv_seq.sv
// Directed bench for xyolo_conv_seq.
module tb_xyolo_conv_seq;

  localparam int unsigned MAW = 10;
  localparam int unsigned VAW = 10;
  localparam int unsigned DW  = 8;
  localparam int unsigned WL  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xyolo_conv_seq_if #(.MEM_ADDR_W(MAW), .VWRITE_ADDR_W(VAW), .DIM_W(DW)) bus ();

  xyolo_conv_seq #(.MEM_ADDR_W(MAW), .VWRITE_ADDR_W(VAW), .DIM_W(DW), .WR_LAT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rd_addr[$], rd_cyc[$], wr_addr[$], wr_cyc[$], acc_cyc[$], res_cyc[$], mp_cyc[$];
  int c_base, c_in_w, c_stride, c_kw, c_kh, c_ow, c_oh, c_vwb, c_mp;
  int t0, dc;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.vread_enB === 1'b1) begin rd_addr.push_back(int'(bus.vread_addrB)); rd_cyc.push_back(cyc); end
    if (bus.vwrite_enB === 1'b1) begin wr_addr.push_back(int'(bus.vwrite_addrB)); wr_cyc.push_back(cyc); end
    if (bus.ld_acc === 1'b1) acc_cyc.push_back(cyc);
    if (bus.ld_res === 1'b1) res_cyc.push_back(cyc);
    if (bus.ld_mp === 1'b1)  mp_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_cyc.delete();
    acc_cyc.delete(); res_cyc.delete(); mp_cyc.delete();
  endtask

  task automatic set_cfg(input int base, input int in_w, input int stride, input int kw, input int kh,
                         input int ow, input int oh, input int vwb, input int mp);
    c_base = base; c_in_w = in_w; c_stride = stride; c_kw = kw; c_kh = kh;
    c_ow = ow; c_oh = oh; c_vwb = vwb; c_mp = mp;
    bus.base_addr   = MAW'(base);
    bus.in_w        = DW'(in_w);
    bus.stride      = DW'(stride);
    bus.ker_w       = DW'(kw);
    bus.ker_h       = DW'(kh);
    bus.out_w       = DW'(ow);
    bus.out_h       = DW'(oh);
    bus.vwrite_base = VAW'(vwb);
    bus.maxpool_en  = (mp != 0);
  endtask

  // Pulse run for one cycle (called at a negedge); returns the run cycle
  task automatic start_run(input string tag, output int t);
    bus.run = 1'b1;
    t = cyc;
    @(negedge clk);
    bus.run = 1'b0;
    chk({tag, "_done_fall"}, int'(bus.done), 0);
  endtask

  task automatic wait_done(input string tag, output int d);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, int'(bus.done), 1);
    d = cyc;
  endtask

  // Compare recorded events against a direct loop model of the convolution walk
  task automatic check_run(input string tag, input int t, input int d);
    int tp, nout, n, idx, ea;
    tp = c_kw * c_kh;
    nout = c_ow * c_oh;
    n = nout * tp;
    chk({tag, "_nrd"}, rd_addr.size(), n);
    chk({tag, "_nwr"}, wr_addr.size(), nout);
    chk({tag, "_nacc"}, acc_cyc.size(), nout);
    chk({tag, "_nres"}, res_cyc.size(), nout);
    chk({tag, "_nmp"}, mp_cyc.size(), (c_mp != 0) ? nout : 0);
    chk({tag, "_done_cyc"}, d, (n > 0) ? t + n + 6 : t + 2);
    idx = 0;
    for (int oy = 0; oy < c_oh; oy++)
      for (int ox = 0; ox < c_ow; ox++)
        for (int ky = 0; ky < c_kh; ky++)
          for (int kx = 0; kx < c_kw; kx++) begin
            ea = (c_base + oy * c_stride * c_in_w + ox * c_stride + ky * c_in_w + kx) % 1024;
            if (idx < rd_addr.size()) begin
              chk($sformatf("%s_rdaddr%0d", tag, idx), rd_addr[idx], ea);
              chk($sformatf("%s_rdcyc%0d", tag, idx), rd_cyc[idx], t + 1 + idx);
            end
            idx++;
          end
    for (int k = 0; k < nout; k++) begin
      if (k < acc_cyc.size()) chk($sformatf("%s_acc%0d", tag, k), acc_cyc[k], t + 3 + k * tp);
      if (k < res_cyc.size()) chk($sformatf("%s_res%0d", tag, k), res_cyc[k], t + 2 + k * tp + tp);
      if (k < wr_cyc.size()) begin
        chk($sformatf("%s_wrcyc%0d", tag, k), wr_cyc[k], t + 5 + k * tp + tp);
        chk($sformatf("%s_wraddr%0d", tag, k), wr_addr[k], (c_vwb + k) % 1024);
      end
      if (c_mp != 0 && k < mp_cyc.size()) chk($sformatf("%s_mp%0d", tag, k), mp_cyc[k], t + 2 + k * tp + tp);
    end
  endtask

  int s1_exp[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int s2_exp[4]  = '{5, 7, 9, 11};
  int s5_exp[8]  = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
  int s5b_exp[8] = '{3, 4, 5, 6, 23, 24, 25, 26};
  int s5b_wr[4]  = '{1022, 1023, 0, 1};

  initial begin
    rst = 1'b0;
    bus.run = 1'b0;
    set_cfg(0, 4, 1, 3, 3, 2, 2, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_done", int'(bus.done), 1);
    chk("rst_vread_en", int'(bus.vread_enB), 0);
    chk("rst_vwrite_en", int'(bus.vwrite_enB), 0);
    chk("rst_ld_acc", int'(bus.ld_acc), 0);
    chk("rst_ld_res", int'(bus.ld_res), 0);
    chk("rst_ld_mp", int'(bus.ld_mp), 0);
    chk("rst_vread_addr", int'(bus.vread_addrB), 0);
    chk("rst_vwrite_addr", int'(bus.vwrite_addrB), 0);

    // 3x3 kernel over 2x2 outputs, run on the first cycle out of reset
    clear_q();
    rst = 1'b1;
    start_run("s1", t0);
    wait_done("s1", dc);
    for (int i = 0; i < 9; i++)
      if (i < rd_addr.size()) chk($sformatf("s1_first_out%0d", i), rd_addr[i], s1_exp[i]);
    chk("s1_done_42", dc - t0, 42);
    check_run("s1", t0, dc);

    // 1x1 kernel, stride 2
    clear_q();
    set_cfg(5, 16, 2, 1, 1, 4, 1, 100, 0);
    start_run("s2", t0);
    wait_done("s2", dc);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_addr.size()) chk($sformatf("s2_rd%0d", i), rd_addr[i], s2_exp[i]);
      if (i < acc_cyc.size() && i < res_cyc.size()) chk($sformatf("s2_acc_eq_res%0d", i), acc_cyc[i], res_cyc[i]);
      if (i < res_cyc.size()) chk($sformatf("s2_res_cyc%0d", i), res_cyc[i], t0 + 3 + i);
      if (i < wr_cyc.size() && i < res_cyc.size()) chk($sformatf("s2_wr_lat%0d", i), wr_cyc[i] - res_cyc[i], 3);
    end
    check_run("s2", t0, dc);

    // maxpool enabled, 2x2 kernel, single output
    clear_q();
    set_cfg(0, 8, 1, 2, 2, 1, 1, 7, 1);
    start_run("s3a", t0);
    wait_done("s3a", dc);
    chk("s3a_mp_count", mp_cyc.size(), 1);
    if (mp_cyc.size() > 0 && res_cyc.size() > 0) chk("s3a_mp_with_res", mp_cyc[0], res_cyc[0]);
    check_run("s3a", t0, dc);

    // maxpool disabled
    clear_q();
    set_cfg(0, 8, 1, 2, 2, 1, 1, 7, 0);
    start_run("s3b", t0);
    wait_done("s3b", dc);
    chk("s3b_mp_never", mp_cyc.size(), 0);
    check_run("s3b", t0, dc);

    // zero output width
    clear_q();
    set_cfg(0, 8, 1, 3, 3, 0, 2, 0, 1);
    start_run("s4", t0);
    wait_done("s4", dc);
    chk("s4_done_2", dc - t0, 2);
    check_run("s4", t0, dc);

    // read address wrap at the top of the vread space
    clear_q();
    set_cfg(1020, 8, 4, 4, 1, 2, 1, 0, 0);
    start_run("s5", t0);
    wait_done("s5", dc);
    for (int i = 0; i < 8; i++)
      if (i < rd_addr.size()) chk($sformatf("s5_wrap%0d", i), rd_addr[i], s5_exp[i]);
    check_run("s5", t0, dc);

    // row advance with stride 2 and vwrite address wrap
    clear_q();
    set_cfg(3, 10, 2, 2, 1, 2, 2, 1022, 0);
    start_run("s5b", t0);
    wait_done("s5b", dc);
    for (int i = 0; i < 8; i++)
      if (i < rd_addr.size()) chk($sformatf("s5b_rd%0d", i), rd_addr[i], s5b_exp[i]);
    for (int i = 0; i < 4; i++)
      if (i < wr_addr.size()) chk($sformatf("s5b_wr%0d", i), wr_addr[i], s5b_wr[i]);
    check_run("s5b", t0, dc);

    // reset mid-RUN with a result pending in the write delay line
    clear_q();
    set_cfg(0, 4, 1, 3, 3, 2, 2, 0, 0);
    start_run("s6", t0);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s6_rst_done", int'(bus.done), 1);
    chk("s6_rst_vread_en", int'(bus.vread_enB), 0);
    chk("s6_rst_vread_addr", int'(bus.vread_addrB), 0);
    chk("s6_rst_ld_res", int'(bus.ld_res), 0);
    chk("s6_rst_vwrite_addr", int'(bus.vwrite_addrB), 0);
    clear_q();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("s6_no_wr_after_rst", wr_addr.size(), 0);
    chk("s6_no_rd_after_rst", rd_addr.size(), 0);
    chk("s6_no_res_after_rst", res_cyc.size(), 0);
    chk("s6_idle_done", int'(bus.done), 1);
    clear_q();
    start_run("s6r", t0);
    wait_done("s6r", dc);
    check_run("s6r", t0, dc);

    // run and config changes while busy are ignored
    clear_q();
    set_cfg(0, 8, 2, 2, 2, 3, 1, 0, 0);
    start_run("s7", t0);
    bus.run = 1'b1;
    bus.base_addr = MAW'(500);
    bus.out_w = DW'(7);
    bus.maxpool_en = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    wait_done("s7", dc);
    chk("s7_wr_count", wr_addr.size(), 3);
    check_run("s7", t0, dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
